mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/rv32i_types.sv | 20 ++
 rtl/register.sv | 29 ++
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared type package for the memory-side blocks of the RV32I core.
// Holds the memory port arbiter FSM state and the port identifier.
package rv32i_types;

  // Arbiter FSM: IDLE picks a port, BUSY_x owns the downstream memory,
  // DONE pulses the completion to the granted port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // CPU-side port identifier; A = instruction port, B = data port.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/register.sv
// Generic load-enabled register with asynchronous active-low clear.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears q to 0
//   load  - when 1, q takes d on the next rising edge
//   d     - data in
//   q     - registered data out
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: every storage element here is a handful of flops, so all of them
  // get an async clear; a known value after reset is cheap and expected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction port A (read only) and data port B
// (read/write) share one downstream memory with one transaction in flight.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   read_a, address_a          - port A request and address (held until resp_a)
//   rdata_a, resp_a            - port A read data and one-cycle completion
//   read_b, write, address_b,
//   wdata, wmask               - port B request, address, write data, byte enables
//   rdata_b, resp_b            - port B read data and one-cycle completion
//   mem_read, mem_write,
//   mem_address, mem_wdata,
//   mem_wmask                  - downstream strobes and payload (holding regs only)
//   mem_rdata, mem_resp        - downstream read data and completion
// Parameter RR_EN: 1 = alternate on a tie, 0 = port B always wins a tie.
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic [31:0] rdata_a,
  output logic        resp_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] rdata_b,
  output logic        resp_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  arb_state_t  state, state_next;
  port_t       last_grant;

  logic        pend_a, pend_b, grant, grant_b;
  logic        busy, cap_a, cap_b;
  logic [31:0] addr_d, addr_q, wdata_d, wdata_q;
  logic [3:0]  wmask_d, wmask_q;
  logic        op_write_d, op_write_q;

  assign pend_a = read_a;
  assign pend_b = read_b | write;

  // On a tie B wins unless round-robin is on and B was granted last.
  assign grant   = (state == IDLE) && (pend_a || pend_b);
  assign grant_b = pend_b && (!pend_a || !RR_EN || (last_grant == PORT_A));

  // Port A is read-only, so its write payload is zero. A simultaneous
  // read_b and write on port B is a write.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    addr_d     = address_a;
    wdata_d    = '0;
    wmask_d    = '0;
    op_write_d = 1'b0;
    if (grant_b) begin
      addr_d     = address_b;
      wdata_d    = wdata;
      wmask_d    = wmask;
      op_write_d = write;
    end
  end

  register #(.WIDTH(32)) u_addr_reg (
    .clk(clk), .rst_n(rst_n), .load(grant), .d(addr_d), .q(addr_q)
  );
  register #(.WIDTH(32)) u_wdata_reg (
    .clk(clk), .rst_n(rst_n), .load(grant), .d(wdata_d), .q(wdata_q)
  );
  register #(.WIDTH(4)) u_wmask_reg (
    .clk(clk), .rst_n(rst_n), .load(grant), .d(wmask_d), .q(wmask_q)
  );
  register #(.WIDTH(1)) u_op_reg (
    .clk(clk), .rst_n(rst_n), .load(grant), .d(op_write_d), .q(op_write_q)
  );

  // last_grant doubles as "port being served" through BUSY and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_A;
    end else begin
      state <= state_next;
      if (grant) begin
        last_grant <= grant_b ? PORT_B : PORT_A;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (pend_a || pend_b) begin
          state_next = grant_b ? BUSY_B : BUSY_A;
        end
      end
      BUSY_A:  if (mem_resp) state_next = DONE;
      BUSY_B:  if (mem_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is captured only for reads; a write leaves rdata_b as it was.
  assign cap_a = (state == BUSY_A) && mem_resp && !op_write_q;
  assign cap_b = (state == BUSY_B) && mem_resp && !op_write_q;

  register #(.WIDTH(32)) u_rdata_a_reg (
    .clk(clk), .rst_n(rst_n), .load(cap_a), .d(mem_rdata), .q(rdata_a)
  );
  register #(.WIDTH(32)) u_rdata_b_reg (
    .clk(clk), .rst_n(rst_n), .load(cap_b), .d(mem_rdata), .q(rdata_b)
  );

  // Downstream side is gated by BUSY so nothing leaks out in IDLE/DONE.
  assign busy        = (state == BUSY_A) || (state == BUSY_B);
  assign mem_read    = busy && !op_write_q;
  assign mem_write   = busy && op_write_q;
  assign mem_address = busy ? addr_q  : '0;
  assign mem_wdata   = busy ? wdata_q : '0;
  assign mem_wmask   = busy ? wmask_q : '0;

  assign resp_a = (state == DONE) && (last_grant == PORT_A);
  assign resp_b = (state == DONE) && (last_grant == PORT_B);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances (RR_EN=1 and
// RR_EN=0) share the request inputs; sel_fixed picks whose outputs the
// memory responder and the scoreboard monitors observe.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_exp_t;

  typedef struct {
    bit          is_b;
    logic [31:0] rdata;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_a, read_b, write;
  logic [31:0] address_a, address_b, wdata;
  logic [3:0]  wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  logic [31:0] r_rdata_a, r_rdata_b, r_mem_address, r_mem_wdata;
  logic        r_resp_a, r_resp_b, r_mem_read, r_mem_write;
  logic [3:0]  r_mem_wmask;
  logic [31:0] f_rdata_a, f_rdata_b, f_mem_address, f_mem_wdata;
  logic        f_resp_a, f_resp_b, f_mem_read, f_mem_write;
  logic [3:0]  f_mem_wmask;

  logic        sel_fixed = 1'b0;
  logic [31:0] s_rdata_a, s_rdata_b, s_mem_address, s_mem_wdata;
  logic        s_resp_a, s_resp_b, s_mem_read, s_mem_write;
  logic [3:0]  s_mem_wmask;

  int checks = 0;
  int errors = 0;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];

  int          resp_delay = 0;
  bit          resp_en    = 1'b1;
  logic [31:0] rd_val     = 32'h0;
  logic [31:0] model_a    = 32'h0;
  logic [31:0] model_b    = 32'h0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .rdata_a(r_rdata_a), .resp_a(r_resp_a),
    .read_b(read_b), .write(write), .address_b(address_b), .wdata(wdata),
    .wmask(wmask), .rdata_b(r_rdata_b), .resp_b(r_resp_b),
    .mem_read(r_mem_read), .mem_write(r_mem_write), .mem_address(r_mem_address),
    .mem_wdata(r_mem_wdata), .mem_wmask(r_mem_wmask),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_port_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .rdata_a(f_rdata_a), .resp_a(f_resp_a),
    .read_b(read_b), .write(write), .address_b(address_b), .wdata(wdata),
    .wmask(wmask), .rdata_b(f_rdata_b), .resp_b(f_resp_b),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_address(f_mem_address),
    .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  assign s_rdata_a     = sel_fixed ? f_rdata_a     : r_rdata_a;
  assign s_rdata_b     = sel_fixed ? f_rdata_b     : r_rdata_b;
  assign s_resp_a      = sel_fixed ? f_resp_a      : r_resp_a;
  assign s_resp_b      = sel_fixed ? f_resp_b      : r_resp_b;
  assign s_mem_read    = sel_fixed ? f_mem_read    : r_mem_read;
  assign s_mem_write   = sel_fixed ? f_mem_write   : r_mem_write;
  assign s_mem_address = sel_fixed ? f_mem_address : r_mem_address;
  assign s_mem_wdata   = sel_fixed ? f_mem_wdata   : r_mem_wdata;
  assign s_mem_wmask   = sel_fixed ? f_mem_wmask   : r_mem_wmask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitors: compare each new downstream strobe and each completion pulse
  // against the next expectation queued by the stimulus.
  logic      prev_strobe = 1'b0;
  mem_exp_t  me;
  resp_exp_t re;
  always @(negedge clk) begin
    if ((s_mem_read || s_mem_write) && !prev_strobe) begin
      check("strobe_exclusive", 32'(s_mem_read & s_mem_write), 32'h0);
      if (exp_mem.size() == 0) begin
        check("unexpected_strobe", 32'h1, 32'h0);
      end else begin
        me = exp_mem.pop_front();
        check("mem_write_op", 32'(s_mem_write), 32'(me.is_write));
        check("mem_read_op", 32'(s_mem_read), 32'(!me.is_write));
        check("mem_address", s_mem_address, me.addr);
        if (me.is_write) begin
          check("mem_wdata", s_mem_wdata, me.wdata);
          check("mem_wmask", 32'(s_mem_wmask), 32'(me.wmask));
        end
      end
    end
    prev_strobe = s_mem_read || s_mem_write;
    if (s_resp_a || s_resp_b) begin
      check("resp_exclusive", 32'(s_resp_a & s_resp_b), 32'h0);
      if (exp_resp.size() == 0) begin
        check("unexpected_resp", 32'h1, 32'h0);
      end else begin
        re = exp_resp.pop_front();
        check("resp_port_b", 32'(s_resp_b), 32'(re.is_b));
        check("resp_rdata", re.is_b ? s_rdata_b : s_rdata_a, re.rdata);
      end
    end
  end

  // Downstream memory model: answers a strobe after resp_delay extra cycles,
  // checking that the strobe and address stay put while it stalls.
  logic [31:0] stall_addr;
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if ((s_mem_read || s_mem_write) && resp_en) begin
        stall_addr = s_mem_address;
        for (int i = 0; i < resp_delay; i++) begin
          @(negedge clk);
          check("stall_address", s_mem_address, stall_addr);
          check("stall_strobe", 32'(s_mem_read | s_mem_write), 32'h1);
          check("stall_no_resp", 32'(s_resp_a | s_resp_b), 32'h0);
        end
        mem_resp  = 1'b1;
        mem_rdata = rd_val;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  task automatic push_txn(input bit is_b, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] exp_rd;
    exp_mem.push_back('{is_write: wr, addr: addr, wdata: wd, wmask: wm});
    if (!is_b) begin
      model_a = rd_val;
      exp_rd  = model_a;
    end else begin
      if (!wr) model_b = rd_val;
      exp_rd = model_b;
    end
    exp_resp.push_back('{is_b: is_b, rdata: exp_rd});
  endtask

  task automatic wait_resp(input bit any, input bit is_b, input string name);
    int n = 0;
    while (!(any ? (s_resp_a || s_resp_b) : (is_b ? s_resp_b : s_resp_a)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n >= 100), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    read_a = 1'b0; read_b = 1'b0; write = 1'b0;
    model_a = 32'h0;
    model_b = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_b(input bit rb, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm);
    push_txn(1'b1, wr, addr, wd, wm);
    @(negedge clk);
    read_b = rb; write = wr; address_b = addr; wdata = wd; wmask = wm;
    wait_resp(1'b0, 1'b1, "resp_b_timeout");
    read_b = 1'b0; write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    read_a = 1'b0; read_b = 1'b0; write = 1'b0;
    address_a = 32'h0; address_b = 32'h0; wdata = 32'h0; wmask = 4'h0;
    do_reset();

    // Reset state.
    check("rst_mem_read", 32'(s_mem_read), 32'h0);
    check("rst_mem_write", 32'(s_mem_write), 32'h0);
    check("rst_mem_address", s_mem_address, 32'h0);
    check("rst_resp", 32'({s_resp_a, s_resp_b}), 32'h0);
    check("rst_rdata_a", s_rdata_a, 32'h0);
    check("rst_rdata_b", s_rdata_b, 32'h0);

    // Lone A read at minimum latency.
    rd_val = 32'hDEADBEEF;
    push_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    read_a = 1'b1; address_a = 32'h100;
    @(negedge clk);
    check("lat_c1_mem_read", 32'(s_mem_read), 32'h1);
    check("lat_c1_address", s_mem_address, 32'h100);
    check("lat_c1_resp_a", 32'(s_resp_a), 32'h0);
    @(negedge clk);
    check("lat_c2_resp_a", 32'(s_resp_a), 32'h1);
    check("lat_c2_rdata_a", s_rdata_a, 32'hDEADBEEF);
    read_a = 1'b0;
    @(negedge clk);
    check("lat_c3_resp_a", 32'(s_resp_a), 32'h0);
    check("lat_c3_mem_read", 32'(s_mem_read), 32'h0);
    check("hold_rdata_a", s_rdata_a, 32'hDEADBEEF);

    // B read, then B write must leave rdata_b alone.
    rd_val = 32'hCAFE0001;
    run_b(1'b1, 1'b0, 32'h1F0, 32'h0, 4'h0);
    rd_val = 32'h77777777;
    run_b(1'b0, 1'b1, 32'h200, 32'h12345678, 4'h3);
    // read_b and write together: a write.
    run_b(1'b1, 1'b1, 32'h204, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    check("wr_keeps_rdata_b", s_rdata_b, 32'hCAFE0001);

    // Slow memory; request dropped and address changed while busy.
    resp_delay = 10;
    rd_val = 32'h00001234;
    push_txn(1'b0, 1'b0, 32'h180, 32'h0, 4'h0);
    @(negedge clk);
    read_a = 1'b1; address_a = 32'h180;
    repeat (2) @(negedge clk);
    read_a = 1'b0; address_a = 32'hFFFF0000;
    wait_resp(1'b0, 1'b0, "slow_resp_timeout");
    resp_delay = 0;

    // Reset mid BUSY_A with the memory stalled: abort, no late resp.
    resp_en = 1'b0;
    exp_mem.push_back('{is_write: 1'b0, addr: 32'h500, wdata: 32'h0, wmask: 4'h0});
    @(negedge clk);
    read_a = 1'b1; address_a = 32'h500;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_read", 32'(s_mem_read), 32'h0);
    check("abort_mem_address", s_mem_address, 32'h0);
    check("abort_resp_a", 32'(s_resp_a), 32'h0);
    check("abort_rdata_a", s_rdata_a, 32'h0);
    read_a = 1'b0;
    model_a = 32'h0; model_b = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    repeat (6) @(negedge clk);
    rd_val = 32'h5555AAAA;
    push_txn(1'b0, 1'b0, 32'h504, 32'h0, 4'h0);
    @(negedge clk);
    read_a = 1'b1; address_a = 32'h504;
    wait_resp(1'b0, 1'b0, "post_abort_timeout");
    read_a = 1'b0;

    // Round-robin tie, both held for four grants: B, A, B, A.
    do_reset();
    rd_val = 32'h0BADF00D;
    for (int k = 0; k < 2; k++) begin
      push_txn(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
      push_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    end
    @(negedge clk);
    read_a = 1'b1; address_a = 32'h300;
    read_b = 1'b1; address_b = 32'h400;
    for (int k = 0; k < 4; k++) begin
      wait_resp(1'b1, 1'b0, "rr_timeout");
      if (k == 3) begin
        read_a = 1'b0; read_b = 1'b0;
      end
      @(negedge clk);
    end

    // Fixed priority: B wins every tie while held, then A is served.
    sel_fixed = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) push_txn(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    push_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    @(negedge clk);
    read_a = 1'b1; address_a = 32'h300;
    read_b = 1'b1; address_b = 32'h400;
    for (int k = 0; k < 4; k++) begin
      wait_resp(1'b1, 1'b0, "fixed_timeout");
      if (k == 3) read_b = 1'b0;
      @(negedge clk);
    end
    wait_resp(1'b0, 1'b0, "fixed_a_timeout");
    read_a = 1'b0;

    repeat (5) @(negedge clk);
    check("exp_mem_drained", exp_mem.size(), 32'h0);
    check("exp_resp_drained", exp_resp.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
